tristate_bus_arbiter: RTL and testbench



---
 rtl/tristate_bus_arbiter_pkg.sv | 8 +
 rtl/tristate_bus_arbiter_picker.sv | 19 +
 rtl/tristate_bus_arbiter.sv | 97 +++++++++
 tb/tb_tristate_bus_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// tristate_bus_arbiter_pkg: state encoding shared by the bus arbiter files
package tristate_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;
endpackage

// File: rtl/tristate_bus_arbiter_picker.sv
// round_robin_picker: first set request strictly after the last owner, wrapping around
module round_robin_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_rr_last,
  output logic [$clog2(N)-1:0] o_pick,
  output logic                 o_valid
);
  localparam int IDX_W = $clog2(N);
  // scan from farthest to nearest so the nearest set bit after rr_last wins
  always_comb begin
    o_pick = '0;
    o_valid = |i_req;
    for (int i = N; i >= 1; i--) begin
      if (i_req[(int'(i_rr_last) + i) % N]) o_pick = IDX_W'((int'(i_rr_last) + i) % N);
    end
  end
endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner of a shared tristate bus with forced high-Z turnaround
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N           = 4,
  parameter int WIDTH       = 32,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]     bus_out,
  output logic [N-1:0]         grant,
  output logic                 bus_oe,
  output logic [$clog2(N)-1:0] owner_idx,
  output logic                 busy
);
  localparam int IDX_W = $clog2(N);
  localparam int HW    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW    = $clog2(TURN_CYCLES + 1);

  state_t           r_state;
  logic [N-1:0]     r_grant;
  logic             r_oe;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr;
  logic [HW-1:0]    r_hold;
  logic [TW-1:0]    r_turn;
  logic [IDX_W-1:0] w_pick;
  logic             w_valid;
  logic             w_others;
  logic             w_release;
  logic             w_turn_done;

  round_robin_picker #(.N(N)) u_picker (
    .i_req    (req),
    .i_rr_last(r_rr),
    .o_pick   (w_pick),
    .o_valid  (w_valid)
  );

  // hold_cnt only advances while a competitor waits, so a lone owner is never preempted
  assign w_others    = |(req & ~r_grant);
  assign w_release   = !req[r_owner] || ((MAX_HOLD != 0) && w_others && (r_hold == HW'(MAX_HOLD - 1)));
  assign w_turn_done = (r_turn == TW'(TURN_CYCLES - 1));

  // arbitration FSM: IDLE/TURN hand the bus to the picker's choice, DRIVE holds until release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_oe    <= 1'b0;
      r_owner <= '0;
      r_rr    <= IDX_W'(N - 1);
      r_hold  <= '0;
      r_turn  <= '0;
    end else begin
      case (r_state)
        IDLE, TURN: begin
          if (r_state == IDLE || w_turn_done) begin
            if (w_valid) begin
              r_state <= DRIVE;
              r_grant <= N'(1) << w_pick;
              r_oe    <= 1'b1;
              r_owner <= w_pick;
              r_rr    <= w_pick;
              r_hold  <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_turn <= r_turn + TW'(1);
          end
        end
        DRIVE: begin
          if (w_release) begin
            r_state <= TURN;
            r_grant <= '0;
            r_oe    <= 1'b0;
            r_turn  <= '0;
          end else begin
            r_hold <= !w_others ? '0 : (r_hold == HW'(MAX_HOLD)) ? r_hold : r_hold + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign bus_oe    = r_oe;
  assign owner_idx = r_owner;
  assign busy      = (r_state != IDLE);
  assign bus_out   = r_oe ? data_in[r_owner*WIDTH +: WIDTH] : {WIDTH{1'bz}};
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: directed vectors plus a randomized contention sweep
module tb_tristate_bus_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  wire  [W-1:0]   bus_out;
  logic [N-1:0]   grant;
  logic           bus_oe;
  logic [1:0]     owner_idx;
  logic           busy;
  int n_cmp = 0;
  int n_err = 0;

  tristate_bus_arbiter #(.N(N), .WIDTH(W), .MAX_HOLD(4), .TURN_CYCLES(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .bus_out  (bus_out),
    .grant    (grant),
    .bus_oe   (bus_oe),
    .owner_idx(owner_idx),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    #3;
    reset = 1'b0;
  endtask

  task automatic drv(input string tag, input int k);
    check({tag, " grant"}, 64'(grant), 64'(1) << k);
    check({tag, " oe"}, 64'(bus_oe), 64'(1));
    check({tag, " bus"}, 64'(bus_out), 64'(data_in[k*W +: W]));
  endtask

  task automatic zc(input string tag);
    check({tag, " grant"}, 64'(grant), 64'(0));
    check({tag, " oe"}, 64'(bus_oe), 64'(0));
    check({tag, " busy"}, 64'(busy), 64'(1));
  endtask

  initial begin
    logic [N-1:0] prev_grant;
    logic         prev_oe;
    int           k;
    #2;
    check("rst grant", 64'(grant), 64'(0));
    check("rst oe", 64'(bus_oe), 64'(0));
    check("rst owner", 64'(owner_idx), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    reset = 1'b0;
    data_in[0*W +: W] = 32'h12345678;
    data_in[2*W +: W] = 32'hDEADBEEF;
    req = 4'b0100;
    cyc();
    drv("t1 own2", 2);
    check("t1 owner", 64'(owner_idx), 64'(2));
    #2;
    reset = 1'b1;
    #1;
    check("t1 async grant", 64'(grant), 64'(0));
    check("t1 async oe", 64'(bus_oe), 64'(0));
    check("t1 async busy", 64'(busy), 64'(0));
    check("t1 async owner", 64'(owner_idx), 64'(0));
    reset = 1'b0;
    req = 4'b0001;
    cyc();
    drv("t1 regrant", 0);
    req = '0;
    cyc();
    zc("t1 turn");
    cyc();
    check("t1 idle", 64'(busy), 64'(0));
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      drv("t2 drive", 0);
    end
    req = '0;
    cyc();
    zc("t2 turn");
    cyc();
    check("t2 idle", 64'(busy), 64'(0));
    do_reset();
    for (int i = 0; i < N; i++) data_in[i*W +: W] = 32'hA0000000 | 32'(i * 17 + 3);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        cyc();
        drv($sformatf("t3 own%0d", i % 4), i % 4);
      end
      cyc();
      zc("t3 turn");
    end
    req = '0;
    cyc();
    check("t3 idle", 64'(busy), 64'(0));
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      cyc();
      drv("t4 alone", 1);
    end
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      drv("t4 contend", 1);
    end
    cyc();
    zc("t4 turn");
    cyc();
    drv("t4 own3", 3);
    req = '0;
    cyc();
    zc("t4 turn2");
    cyc();
    check("t4 idle", 64'(busy), 64'(0));
    do_reset();
    req = 4'b0001;
    cyc();
    drv("t5 prime", 0);
    req = '0;
    cyc();
    zc("t5 prime turn");
    cyc();
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cyc();
      drv("t5 own2", 2);
    end
    cyc();
    zc("t5 turn");
    cyc();
    drv("t5 own0", 0);
    req = '0;
    cyc();
    cyc();
    do_reset();
    prev_grant = '0;
    prev_oe = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (i % 3 == 0) begin
        req = 4'($urandom);
        data_in = {$urandom, $urandom, $urandom, $urandom};
      end
      cyc();
      check("t6 onehot0", 64'($onehot0(grant)), 64'(1));
      check("t6 oe", 64'(bus_oe), 64'(|grant));
      if (prev_oe && bus_oe) check("t6 turnaround", 64'(grant), 64'(prev_grant));
      if (bus_oe) begin
        k = 0;
        for (int j = 0; j < N; j++) if (grant[j]) k = j;
        check("t6 bus", 64'(bus_out), 64'(data_in[k*W +: W]));
      end
      prev_grant = grant;
      prev_oe = bus_oe;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
